// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Self-synchronising checker for a Fibonacci-style LFSR word stream.
//   Each accepted word is compared against the successor of the previous
//   accepted word; the block hunts for LOCK_COUNT consecutive matches, then
//   counts mismatches while locked and drops lock after UNLOCK_COUNT
//   consecutive mismatches.
//
//   Ports
//     CLK        sole clock, rising edge
//     RST        asynchronous active-high reset
//     CE         word-valid qualifier for I
//     I          received word
//     CLR        synchronous clear of ERR_COUNT
//     LOCKED     registered, 1 while in LOCK
//     ERROR      registered one-cycle pulse per counted mismatch
//     ERR_COUNT  registered saturating mismatch count (LOCK only)
module lfsr_checker #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] POLY         = 16'hD008,
    parameter int unsigned      LOCK_COUNT   = 8,
    parameter int unsigned      UNLOCK_COUNT = 4,
    parameter int unsigned      CNT_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [WIDTH-1:0]     I,
    input  logic                 CLR,
    output logic                 LOCKED,
    output logic                 ERROR,
    output logic [CNT_WIDTH-1:0] ERR_COUNT
);

    // Counters only need to reach their thresholds.
    localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned UC_W = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] p;
    logic            v;
    logic [MC_W-1:0] mc;
    logic [UC_W-1:0] uc;

    logic [WIDTH-1:0] expected_c;
    logic             match_c;
    logic [MC_W-1:0]  mc_inc_c;
    logic [UC_W-1:0]  uc_inc_c;
    logic             count_c;

    // Predicted next word and match decision for the current input.
    always_comb begin
        expected_c = {p[WIDTH-2:0], ^(p & POLY)};
        match_c    = v && (I == expected_c) && (I != '0);
        mc_inc_c   = mc + MC_W'(1);
        uc_inc_c   = uc + UC_W'(1);
        count_c    = CE && (state == LOCK) && !match_c;
    end

    // Hunt/lock state machine with registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= HUNT;
            p      <= '0;
            v      <= 1'b0;
            mc     <= '0;
            uc     <= '0;
            LOCKED <= 1'b0;
            ERROR  <= 1'b0;
        end else begin
            ERROR <= 1'b0;
            if (CE) begin
                // Every accepted word becomes the new reference, good or bad,
                // which is what makes a single corruption cost two mismatches.
                p <= I;
                v <= 1'b1;
                case (state)
                    HUNT: begin
                        if (match_c) begin
                            if (mc_inc_c == MC_W'(LOCK_COUNT)) begin
                                state  <= LOCK;
                                LOCKED <= 1'b1;
                                mc     <= '0;
                                uc     <= '0;
                            end else begin
                                mc <= mc_inc_c;
                            end
                        end else begin
                            mc <= '0;
                        end
                    end
                    LOCK: begin
                        if (match_c) begin
                            uc <= '0;
                        end else begin
                            ERROR <= 1'b1;
                            if (uc_inc_c == UC_W'(UNLOCK_COUNT)) begin
                                state  <= HUNT;
                                LOCKED <= 1'b0;
                                uc     <= '0;
                                mc     <= '0;
                            end else begin
                                uc <= uc_inc_c;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        LOCKED <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; clear wins over a same-edge increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_COUNT <= '0;
        end else if (CLR) begin
            ERR_COUNT <= '0;
        end else if (count_c && (ERR_COUNT != '1)) begin
            ERR_COUNT <= ERR_COUNT + CNT_WIDTH'(1);
        end
    end

endmodule
